bpu_fetch_pc: RTL
=================

// Module: bpu_fetch_pc
// PURPOSE
// - Fetch-stage next-PC generator feeding/consuming the BTB: drives the BTB read index from the current PC.
// - Combines BTB hit with a local 2-bit saturating-counter PHT to predict taken/not-taken and choose the next PC.
// - Accepts resolved-branch updates from EX and redirects on mispredict.
// - Trains the PHT and issues registered write requests to the BTB write port.
// PARAMETERS
// - INDEX_WIDTH  6          BTB/PHT index width; table depth 2**INDEX_WIDTH; tag width TW = 32-INDEX_WIDTH-2
// - RESET_PC     32'h0      pc_o value after reset; bits[1:0] must be 0
// - CTR_INIT     2'b01      reset value of every PHT counter (weakly not-taken)
// PORTS
// - clk_i           in   1    clock; all state updates on posedge
// - rst_ni          in   1    reset, synchronous, active-high
// - stall_i         in   1    hold pc_o (fetch stall); ignored when ex_mispredict_i=1
// - pc_o            out  32   current fetch PC
// - btb_rd_index_o  out  IW   pc_o[INDEX_WIDTH+1:2]
// - btb_valid_i     in   1    BTB entry valid at btb_rd_index_o
// - btb_tag_i       in   TW   BTB tag at btb_rd_index_o
// - btb_target_i    in   32   BTB target at btb_rd_index_o
// - pred_taken_o    out  1    prediction for pc_o, to be piped to EX with the instruction
// - pred_target_o   out  32   predicted target (btb_target_i with [1:0] forced 0)
// - ex_update_i     in   1    EX resolved a branch/jump this cycle
// - ex_pc_i         in   32   PC of resolved branch
// - ex_taken_i      in   1    actual direction
// - ex_target_i     in   32   actual target
// - ex_mispredict_i in   1    EX detected wrong direction or target; valid only with ex_update_i
// - btb_wren_o      out  1    BTB write enable
// - btb_wr_index_o  out  IW   BTB write index
// - btb_wr_tag_o    out  TW   BTB write tag
// - btb_wr_target_o out  32   BTB write target
// BEHAVIOUR
// - Reset (rst_ni=1 at posedge): pc_o=RESET_PC, every PHT entry=CTR_INIT, btb_wren_o=0, write bus regs=0.
// - hit = btb_valid_i && (btb_tag_i == pc_o[31:INDEX_WIDTH+2]); pred_taken_o = hit && pht[rd_idx][1]. Combinational.
// - Next-PC priority, registered: (1) ex_update_i&&ex_mispredict_i -> ex_taken_i ? ex_target_i : ex_pc_i+4;
//   (2) stall_i -> hold; (3) pred_taken_o -> pred_target_o; (4) pc_o+4. Sums mod 2^32 (FFFF_FFFC+4 -> 0).
// - pc_o[1:0] is always 2'b00; bits[1:0] of all target inputs are dropped.
// - PHT update on ex_update_i at posedge, index ex_pc_i[INDEX_WIDTH+1:2]: taken -> +1 saturate at 3; not-taken -> -1 saturate at 0.
// - BTB write: 1-cycle pipelined. ex_update_i&&ex_taken_i at cycle N -> btb_wren_o=1 in cycle N+1 with
//   index/tag from ex_pc_i and target ex_target_i; otherwise btb_wren_o=0 in N+1. Not-taken never writes BTB.
// - Same-index read and update in one cycle: PHT read returns the pre-update value (no bypass).
// - Mispredict while stall_i=1: redirect still taken; stall does not block it.
// - ex_mispredict_i without ex_update_i: ignored.
// - Reset mid-operation: reset wins over redirect/stall/update; a pending BTB write is dropped (btb_wren_o=0 next cycle).
// CONFIGURATION
// - BPU_STATS_EN defined: adds outputs stat_lookup_o, stat_hit_o, stat_mispredict_o (32 bits each);
//   lookup counts cycles with stall_i=0; hit counts those with hit=1; mispredict counts ex_update_i&&ex_mispredict_i.
//   All wrap mod 2^32 and clear to 0 on reset.
// - BPU_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING (INDEX_WIDTH=4, RESET_PC=0, CTR_INIT=01)
// - Reset, no hits, stall_i=0 for 3 cycles -> pc_o 0x0,0x4,0x8,0xC; pred_taken_o=0; btb_wren_o=0.
// - ex_update_i=1, ex_pc_i=0x40, ex_taken_i=1, ex_target_i=0x100 -> next cycle btb_wren_o=1, idx=0, tag=0x1, tgt=0x100.
//   PHT[0] goes 01->10.
// - pc_o=0x40, btb valid, tag 0x1, target 0x100, PHT[0]=10 -> pred_taken_o=1; next pc_o=0x100.
//   Same with tag 0x2 -> pc_o=0x44.
// - Mispredict, ex_pc_i=0x80, ex_taken_i=0, while stall_i=1 -> next pc_o=0x84.
//   Four not-taken updates of 0x80 leave PHT[0]=00; no underflow.
// - pc_o=0xFFFF_FFFC, no hit -> next pc_o=0x0.
//   rst_ni=1 in the cycle after a taken update -> btb_wren_o stays 0 and pc_o=0.
// - BPU_STATS_EN: 5 unstalled cycles, 2 hits, 1 mispredict -> stat_lookup_o=5, stat_hit_o=2, stat_mispredict_o=1.

Source files
------------

// File: rtl/bpu_fetch_pc.sv
// ============================================================================
// Module   : bpu_fetch_pc
// Brief    : Fetch-stage next-PC generator with BTB lookup, 2-bit PHT and
//            EX-driven redirect/training. Optional BPU_STATS_EN adds counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bpu_fetch_pc #(
    parameter int          INDEX_WIDTH = 6,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     stall_i,
    output logic [31:0]              pc_o,
    output logic [INDEX_WIDTH-1:0]   btb_rd_index_o,
    input  logic                     btb_valid_i,
    input  logic [29-INDEX_WIDTH:0]  btb_tag_i,
    input  logic [31:0]              btb_target_i,
    output logic                     pred_taken_o,
    output logic [31:0]              pred_target_o,
    input  logic                     ex_update_i,
    input  logic [31:0]              ex_pc_i,
    input  logic                     ex_taken_i,
    input  logic [31:0]              ex_target_i,
    input  logic                     ex_mispredict_i,
    output logic                     btb_wren_o,
    output logic [INDEX_WIDTH-1:0]   btb_wr_index_o,
    output logic [29-INDEX_WIDTH:0]  btb_wr_tag_o,
    output logic [31:0]              btb_wr_target_o
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]              stat_lookup_o,
    output logic [31:0]              stat_hit_o,
    output logic [31:0]              stat_mispredict_o
`endif
);

    localparam int c_DEPTH = 2 ** INDEX_WIDTH;
    localparam int c_TW    = 30 - INDEX_WIDTH;

    // PC is held word-aligned; bits [1:0] are implicit zeros.
    logic [29:0]              r_pc;
    logic [29:0]              w_pc_next;
    logic [31:0]              w_pc_full;
    logic [1:0]               r_pht [c_DEPTH];

    logic [INDEX_WIDTH-1:0]   w_rd_idx;
    logic [c_TW-1:0]          w_rd_tag;
    logic                     w_hit;
    logic                     w_pred_taken;
    logic                     w_redirect;

    logic [INDEX_WIDTH-1:0]   w_upd_idx;
    logic [1:0]               w_upd_ctr;
    logic [1:0]               w_upd_ctr_next;

    logic                     r_btb_wren;
    logic [INDEX_WIDTH-1:0]   r_btb_wr_index;
    logic [c_TW-1:0]          r_btb_wr_tag;
    logic [31:0]              r_btb_wr_target;

    logic                     w_unused_bits;

    assign w_pc_full    = {r_pc, 2'b00};
    assign w_rd_idx     = w_pc_full[INDEX_WIDTH+1:2];
    assign w_rd_tag     = w_pc_full[31:INDEX_WIDTH+2];
    assign w_hit        = btb_valid_i && (btb_tag_i == w_rd_tag);
    assign w_pred_taken = w_hit && r_pht[w_rd_idx][1];
    assign w_redirect   = ex_update_i && ex_mispredict_i;

    assign pc_o           = w_pc_full;
    assign btb_rd_index_o = w_rd_idx;
    assign pred_taken_o   = w_pred_taken;
    assign pred_target_o  = {btb_target_i[31:2], 2'b00};

    assign w_unused_bits = ^{ex_pc_i[1:0], btb_target_i[1:0], ex_target_i[1:0]};

    always_comb begin
        w_pc_next = r_pc;
        if (w_redirect) begin
            w_pc_next = ex_taken_i ? ex_target_i[31:2] : (ex_pc_i[31:2] + 30'd1);
        end else if (stall_i) begin
            w_pc_next = r_pc;
        end else if (w_pred_taken) begin
            w_pc_next = btb_target_i[31:2];
        end else begin
            w_pc_next = r_pc + 30'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            r_pc <= RESET_PC[31:2];
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Saturating 2-bit counter step for the resolved branch.
    assign w_upd_idx = ex_pc_i[INDEX_WIDTH+1:2];
    assign w_upd_ctr = r_pht[w_upd_idx];

    always_comb begin
        w_upd_ctr_next = w_upd_ctr;
        if (ex_taken_i) begin
            if (w_upd_ctr != 2'b11) begin
                w_upd_ctr_next = w_upd_ctr + 2'b01;
            end
        end else begin
            if (w_upd_ctr != 2'b00) begin
                w_upd_ctr_next = w_upd_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_pht[i] <= CTR_INIT;
            end
        end else if (ex_update_i) begin
            r_pht[w_upd_idx] <= w_upd_ctr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            r_btb_wren      <= 1'b0;
            r_btb_wr_index  <= '0;
            r_btb_wr_tag    <= '0;
            r_btb_wr_target <= '0;
        end else begin
            r_btb_wren <= ex_update_i && ex_taken_i;
            if (ex_update_i && ex_taken_i) begin
                r_btb_wr_index  <= ex_pc_i[INDEX_WIDTH+1:2];
                r_btb_wr_tag    <= ex_pc_i[31:INDEX_WIDTH+2];
                r_btb_wr_target <= {ex_target_i[31:2], 2'b00};
            end
        end
    end

    assign btb_wren_o      = r_btb_wren;
    assign btb_wr_index_o  = r_btb_wr_index;
    assign btb_wr_tag_o    = r_btb_wr_tag;
    assign btb_wr_target_o = r_btb_wr_target;

`ifdef BPU_STATS_EN
    logic [31:0] r_stat_lookup;
    logic [31:0] r_stat_hit;
    logic [31:0] r_stat_mispredict;

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            r_stat_lookup     <= '0;
            r_stat_hit        <= '0;
            r_stat_mispredict <= '0;
        end else begin
            if (!stall_i) begin
                r_stat_lookup <= r_stat_lookup + 32'd1;
                if (w_hit) begin
                    r_stat_hit <= r_stat_hit + 32'd1;
                end
            end
            if (w_redirect) begin
                r_stat_mispredict <= r_stat_mispredict + 32'd1;
            end
        end
    end

    assign stat_lookup_o     = r_stat_lookup;
    assign stat_hit_o        = r_stat_hit;
    assign stat_mispredict_o = r_stat_mispredict;
`endif

endmodule

`default_nettype wire
